// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe: decodes NOPS packed FP operands (half/single/double) into
// sign, double-biased exponent, 53-bit significand, class flags and an
// fclass mask, and queues the decoded results in a 2-entry output buffer.
`timescale 1ns/1ps
module fp_unpack_pipe #(
  parameter int NOPS          = 3,
  parameter bit KILL_DISABLED = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_fmt,
  input  logic [NOPS-1:0]      in_en,
  input  logic [64*NOPS-1:0]   in_ops,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NOPS-1:0]      out_s,
  output logic [11*NOPS-1:0]   out_e,
  output logic [53*NOPS-1:0]   out_m,
  output logic [NOPS-1:0]      out_nan,
  output logic [NOPS-1:0]      out_snan,
  output logic [NOPS-1:0]      out_zero,
  output logic [NOPS-1:0]      out_inf,
  output logic [NOPS-1:0]      out_subn,
  output logic [NOPS-1:0]      out_boxerr,
  output logic [10*NOPS-1:0]   out_class
);

  typedef struct packed {
    logic        s;
    logic [10:0] e;
    logic [52:0] m;
    logic        nan;
    logic        snan;
    logic        zero;
    logic        inf;
    logic        subn;
    logic        boxerr;
    logic [9:0]  cls;
  } lane_t;

  // Decode one 64-bit operand lane into its unpacked form.
  function automatic lane_t decode_lane(input logic [63:0] op, input logic [1:0] fmt,
                                        input logic en);
    lane_t       r;
    logic        boxed;
    logic        sgn;
    logic        e_zero;
    logic        e_max;
    logic        f_nz;
    logic        f_msb;
    logic        normal;
    logic [10:0] e_val;
    logic [52:0] m_val;
    r      = '0;
    boxed  = 1'b1;
    sgn    = 1'b0;
    e_zero = 1'b0;
    e_max  = 1'b0;
    f_nz   = 1'b0;
    f_msb  = 1'b0;
    e_val  = 11'd0;
    m_val  = 53'd0;
    case (fmt)
      2'b00: begin
        boxed  = &op[63:32];
        sgn    = op[31];
        e_zero = (op[30:23] == 8'd0);
        e_max  = &op[30:23];
        f_nz   = |op[22:0];
        f_msb  = op[22];
        e_val  = e_zero ? 11'd897 : ({3'd0, op[30:23]} + 11'd896);
        m_val  = {~e_zero, op[22:0], 29'd0};
      end
      2'b01: begin
        boxed  = 1'b1;
        sgn    = op[63];
        e_zero = (op[62:52] == 11'd0);
        e_max  = &op[62:52];
        f_nz   = |op[51:0];
        f_msb  = op[51];
        e_val  = e_zero ? 11'd1 : op[62:52];
        m_val  = {~e_zero, op[51:0]};
      end
      2'b10: begin
        boxed  = &op[63:16];
        sgn    = op[15];
        e_zero = (op[14:10] == 5'd0);
        e_max  = &op[14:10];
        f_nz   = |op[9:0];
        f_msb  = op[9];
        e_val  = e_zero ? 11'd1009 : ({6'd0, op[14:10]} + 11'd1008);
        m_val  = {~e_zero, op[9:0], 42'd0};
      end
      default: begin
        // Reserved format: every enabled lane reads as a boxing error.
        boxed = 1'b0;
      end
    endcase
    normal = ~e_zero & ~e_max;
    if (!en && KILL_DISABLED) begin
      r = '0;
    end else if (!boxed) begin
      r        = '0;
      r.e      = 11'd2047;
      r.m      = 53'h18000000000000;
      r.nan    = 1'b1;
      r.boxerr = 1'b1;
      r.cls    = 10'h200;
    end else begin
      r.s       = sgn;
      r.e       = e_max ? 11'd2047 : e_val;
      r.m       = m_val;
      r.zero    = e_zero & ~f_nz;
      r.subn    = e_zero & f_nz;
      r.inf     = e_max & ~f_nz;
      r.nan     = e_max & f_nz;
      r.snan    = e_max & f_nz & ~f_msb;
      r.boxerr  = 1'b0;
      r.cls[0]  = sgn & e_max & ~f_nz;
      r.cls[1]  = sgn & normal;
      r.cls[2]  = sgn & e_zero & f_nz;
      r.cls[3]  = sgn & e_zero & ~f_nz;
      r.cls[4]  = ~sgn & e_zero & ~f_nz;
      r.cls[5]  = ~sgn & e_zero & f_nz;
      r.cls[6]  = ~sgn & normal;
      r.cls[7]  = ~sgn & e_max & ~f_nz;
      r.cls[8]  = e_max & f_nz & ~f_msb;
      r.cls[9]  = e_max & f_nz & f_msb;
    end
    return r;
  endfunction

  lane_t [NOPS-1:0] dec_s;
  lane_t [NOPS-1:0] head_r;
  lane_t [NOPS-1:0] tail_r;
  lane_t [NOPS-1:0] head_s;
  lane_t [NOPS-1:0] tail_s;
  logic [1:0]       count_r;
  logic [1:0]       count_s;
  logic             push_s;
  logic             pop_s;

  assign in_ready  = (count_r < 2'd2);
  assign out_valid = (count_r != 2'd0);

  // Combinational decode of every input lane.
  always_comb begin
    dec_s = '0;
    for (int i = 0; i < NOPS; i++) begin
      dec_s[i] = decode_lane(in_ops[64*i +: 64], in_fmt, in_en[i]);
    end
  end

  // Next-state for the 2-entry buffer; head is kept zero whenever empty.
  always_comb begin
    push_s  = in_valid & in_ready & ~flush;
    pop_s   = out_valid & out_ready & ~flush;
    head_s  = head_r;
    tail_s  = tail_r;
    count_s = count_r;
    if (flush) begin
      head_s  = '0;
      tail_s  = '0;
      count_s = 2'd0;
    end else begin
      case (count_r)
        2'd0: begin
          if (push_s) begin
            head_s  = dec_s;
            count_s = 2'd1;
          end else begin
            count_s = 2'd0;
          end
        end
        2'd1: begin
          case ({push_s, pop_s})
            2'b11: head_s = dec_s;
            2'b10: begin
              tail_s  = dec_s;
              count_s = 2'd2;
            end
            2'b01: begin
              head_s  = '0;
              count_s = 2'd0;
            end
            default: count_s = 2'd1;
          endcase
        end
        2'd2: begin
          if (pop_s) begin
            head_s  = tail_r;
            tail_s  = '0;
            count_s = 2'd1;
          end else begin
            count_s = 2'd2;
          end
        end
        default: begin
          head_s  = '0;
          tail_s  = '0;
          count_s = 2'd0;
        end
      endcase
    end
  end

  // Buffer state registers, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
    end else begin
      head_r  <= head_s;
      tail_r  <= tail_s;
      count_r <= count_s;
    end
  end

  for (genvar g = 0; g < NOPS; g++) begin : g_out
    assign out_s[g]              = head_r[g].s;
    assign out_e[11*g +: 11]     = head_r[g].e;
    assign out_m[53*g +: 53]     = head_r[g].m;
    assign out_nan[g]            = head_r[g].nan;
    assign out_snan[g]           = head_r[g].snan;
    assign out_zero[g]           = head_r[g].zero;
    assign out_inf[g]            = head_r[g].inf;
    assign out_subn[g]           = head_r[g].subn;
    assign out_boxerr[g]         = head_r[g].boxerr;
    assign out_class[10*g +: 10] = head_r[g].cls;
  end

endmodule

// File: doc/fp_unpack_pipe.md
# fp_unpack_pipe

Parametrised, pipelined successor to the FPU operand unpacker. It accepts NOPS packed FLEN=64 operands plus a format code through a valid/ready handshake. Each operand is decoded into sign, double-range exponent, 53-bit significand, class flags and a RISC-V fclass mask, and the results are held in a 2-entry output buffer. It sits between the FP register-file read stage and the FMA/divide/convert units, so decode and back-pressure are decoupled from the execute pipeline.

## Interface
Parameters:
- NOPS, 3: operand lanes (1..4); lane i occupies bits [64*i+63:64*i] of packed buses.
- KILL_DISABLED, 1: when 1, a lane whose enable bit is 0 produces all-zero decode outputs.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- flush  in  1  synchronous; empties buffer.
- in_valid  in  1  request valid.
- in_ready  out  1  buffer can accept.
- in_fmt  in  2  00 single, 01 double, 10 half, 11 reserved.
- in_en  in  NOPS  per-lane enable.
- in_ops  in  64*NOPS  packed operands.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_s  out  NOPS  signs.
- out_e  out  11*NOPS  exponents, double bias.
- out_m  out  53*NOPS  significands including implicit bit.
- out_nan, out_snan, out_zero, out_inf, out_subn, out_boxerr  out  NOPS each  class flags.
- out_class  out  10*NOPS  fclass one-hot (bit0 -inf … bit9 qNaN).

## Operation
- Field extraction per fmt:
  - half: sign bit 15, E[14:10], F[9:0], bias 15.
  - single: sign bit 31, E[30:23], F[22:0], bias 127.
  - double: sign bit 63, E[62:52], F[51:0], bias 1023.
- NaN-boxing: half requires op[63:16] all ones; single requires op[63:32] all ones. If unboxed, the lane decodes as canonical qNaN (s=0, e=2047, m=0x18000000000000 i.e. bits 52,51 set) with boxerr=1, nan=1, snan=0.
- Exponent:
  - E all ones -> e=2047.
  - E=0 -> e = 1-bias+1023 (half 1009, single 897, double 1).
  - Otherwise e = E-bias+1023.
- Significand: m[52] = (E!=0); F is left-aligned into m[51:...] and zero-filled below.
- Flags:
  - zero = E==0 & F==0.
  - subn = E==0 & F!=0.
  - inf = Emax & F==0.
  - nan = Emax & F!=0.
  - snan = nan & F msb==0.
- class: standard 10-bit fclass one-hot from s and the flags; exactly one bit is set per enabled lane.
- Lane killed (in_en[i]=0 and KILL_DISABLED=1): all lane outputs are 0, including class.
- fmt 11: every enabled lane decodes as unboxed (canonical qNaN, boxerr=1).
- Buffer: 2-entry FIFO of decoded results; decode is combinational on the input and written at the accepting edge.
- in_ready = (count<2).
- Push on in_valid & in_ready; pop on out_valid & out_ready.
- Simultaneous push and pop: count is unchanged; the head advances and the new entry goes to the tail.
- out_valid = (count!=0); out_* always show the head entry, or 0 when empty.
- flush: count <- 0 at the next edge and any push in that cycle is dropped. flush dominates push/pop.

## Timing
- Reset (async assert, sync-safe deassert): count=0, out_valid=0, in_ready=1, all out_* data =0, buffer contents cleared.
- Latency: an op accepted at edge N is visible at out_* with out_valid=1 after edge N (cycle N+1).
- Throughput: 1 op/cycle sustained while out_ready=1.
- Back-pressure: with out_ready=0, two accepts fill the buffer and in_ready drops the cycle after the second accept.
- in_ready depends only on registered count. No combinational path from out_ready to in_ready.
- Ordering is strictly FIFO. Head data stays stable while out_valid=1 & out_ready=0.
- Reset mid-operation discards all buffered entries.

## Test plan
- Single 1.0 boxed (0xFFFFFFFF3F800000), fmt 00 -> s=0, e=1023, m=0x10000000000000, class bit6.
- Single unboxed 0x000000003F800000 -> canonical qNaN, boxerr=1, class bit9.
- Half subnormal 0xFFFFFFFFFFFF0001 -> subn=1, e=1009, m=bit42 set, class bit5; half sNaN 0x...7C01 -> snan=1, class bit8.
- Double -inf 0xFFF0000000000000 on lane 2 with in_en=3'b100 -> lane 2 class bit0, lanes 0/1 all zero.
- Back-pressure: out_ready=0, push 3 ops -> third stalls with in_ready=0; raise out_ready -> ops drain in order, one per cycle.
- Flush with count=2 plus simultaneous push -> next cycle out_valid=0, count=0; async reset_n low mid-stream -> outputs 0 immediately.
